// File: rtl/fetch_pc_ctrl.sv
// IF-stage PC controller: steers fetch on predictions, redirects on mispredicts/jumps.
// Optional BRPRED_STATS_EN adds saturating branch and mispredict counters.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] instr_IF,
  input  logic        BrPre,
  input  logic [1:0]  PreWrong,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] PC,
  output logic [1:0]  BranchPC_IF,
  output logic [1:0]  BranchPC_ID,
  output logic        BrPre_ID,
  output logic        valid_ID,
`ifdef BRPRED_STATS_EN
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt,
`endif
  output logic        flush_IF
);

  logic [31:0] r_pc;
  logic [31:0] r_pc4_id;
  logic [31:0] r_tgt_id;
  logic        r_brpre_id;
  logic [1:0]  r_bpc_id;
  logic        r_valid_id;

  logic [31:0] w_pc4_if;
  logic [31:0] w_tgt_if;
  logic        w_mispredict;
  logic        w_redirect;
  logic [31:0] w_next_pc;

  assign w_pc4_if     = r_pc + 32'd4;
  assign w_tgt_if     = w_pc4_if + {{14{instr_IF[15]}}, instr_IF[15:0], 2'b00};
  // PreWrong bit 0 set means the branch went the other way (01 or 11)
  assign w_mispredict = r_valid_id & PreWrong[0];
  assign w_redirect   = w_mispredict | redirect_valid;

  always_comb begin
    w_next_pc = w_pc4_if;
    if (w_mispredict && !PreWrong[1]) w_next_pc = r_pc4_id;
    else if (w_mispredict)            w_next_pc = r_tgt_id;
    else if (redirect_valid)          w_next_pc = redirect_pc;
    else if (BrPre)                   w_next_pc = w_tgt_if;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_pc4_id   <= 32'd0;
      r_tgt_id   <= 32'd0;
      r_brpre_id <= 1'b0;
      r_bpc_id   <= 2'd0;
      r_valid_id <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_next_pc;
      if (w_redirect) begin
        r_brpre_id <= 1'b0;
        r_bpc_id   <= 2'd0;
        r_valid_id <= 1'b0;
      end else begin
        r_pc4_id   <= w_pc4_if;
        r_tgt_id   <= w_tgt_if;
        r_brpre_id <= BrPre;
        r_bpc_id   <= r_pc[3:2];
        r_valid_id <= 1'b1;
      end
    end
  end

`ifdef BRPRED_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= 32'd0;
      r_mispred_cnt <= 32'd0;
    end else if (!stall) begin
      if (r_valid_id && (PreWrong != 2'b10) && (r_branch_cnt != 32'hFFFF_FFFF))
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_mispredict && (r_mispred_cnt != 32'hFFFF_FFFF))
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;
`endif

  assign PC          = r_pc;
  assign BranchPC_IF = r_pc[3:2];
  assign BranchPC_ID = r_bpc_id;
  assign BrPre_ID    = r_brpre_id;
  assign valid_ID    = r_valid_id;
  assign flush_IF    = ~stall & w_redirect;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed vector table plus randomized run
// against a slot-level reference model.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, BrPre, redirect_valid;
  logic [31:0] instr_IF, redirect_pc;
  logic [1:0]  PreWrong;
  logic [31:0] PC;
  logic [1:0]  BranchPC_IF, BranchPC_ID;
  logic        BrPre_ID, valid_ID, flush_IF;
`ifdef BRPRED_STATS_EN
  logic [31:0] branch_cnt, mispred_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_IF(instr_IF), .BrPre(BrPre),
    .PreWrong(PreWrong), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .PC(PC), .BranchPC_IF(BranchPC_IF), .BranchPC_ID(BranchPC_ID),
    .BrPre_ID(BrPre_ID), .valid_ID(valid_ID),
`ifdef BRPRED_STATS_EN
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
`endif
    .flush_IF(flush_IF)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stall, brpre, rv;
    logic [1:0]  pw;
    logic [15:0] imm;
    logic [31:0] rpc;
    logic        chk_flush, exp_flush;
    logic [31:0] exp_pc;
    logic        exp_valid, exp_brpre_id;
    logic [1:0]  exp_bpc_id;
    logic        chk_cnt;
    logic [31:0] exp_bc, exp_mc;
  } vec_t;

  vec_t vt[16];

  // slot-level reference model state
  logic [31:0] m_pc, m_pc4, m_tgt, m_bc, m_mc;
  logic        m_valid, m_brpre;
  logic [1:0]  m_bpc;

  initial begin
    //        rst stl bp rv  pw     imm       rpc      chkF expF  pc      v  bpID bpcID cc  bc  mc
    vt[0]  = '{1, 0, 0, 0, 2'b10, 16'h0,    32'h0,   0, 0, 32'h00, 0, 0, 2'd0, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 2'b10, 16'h0,    32'h0,   1, 0, 32'h04, 1, 0, 2'd0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 2'b10, 16'h0,    32'h0,   1, 0, 32'h08, 1, 0, 2'd1, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 2'b10, 16'h0,    32'h0,   1, 0, 32'h0C, 1, 0, 2'd2, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 1, 2'b10, 16'h0,    32'h40,  1, 1, 32'h40, 0, 0, 2'd0, 0, 0, 0};
    vt[5]  = '{0, 0, 1, 0, 2'b10, 16'h0003, 32'h0,   1, 0, 32'h50, 1, 1, 2'd0, 0, 0, 0};
    vt[6]  = '{0, 0, 1, 0, 2'b01, 16'h0010, 32'h0,   1, 1, 32'h44, 0, 0, 2'd0, 1, 1, 1};
    vt[7]  = '{0, 0, 0, 0, 2'b01, 16'h0,    32'h0,   1, 0, 32'h48, 1, 0, 2'd1, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 1, 2'b10, 16'h0,    32'h80,  1, 1, 32'h80, 0, 0, 2'd0, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 2'b10, 16'hFFFF, 32'h0,   1, 0, 32'h84, 1, 0, 2'd0, 0, 0, 0};
    vt[10] = '{0, 1, 0, 0, 2'b11, 16'h0,    32'h0,   1, 0, 32'h84, 1, 0, 2'd0, 0, 0, 0};
    vt[11] = '{0, 1, 0, 0, 2'b11, 16'h0,    32'h0,   1, 0, 32'h84, 1, 0, 2'd0, 0, 0, 0};
    vt[12] = '{0, 0, 0, 0, 2'b11, 16'h0,    32'h0,   1, 1, 32'h80, 0, 0, 2'd0, 1, 2, 2};
    vt[13] = '{0, 0, 0, 0, 2'b10, 16'h0,    32'h0,   1, 0, 32'h84, 1, 0, 2'd0, 0, 0, 0};
    vt[14] = '{1, 1, 0, 1, 2'b11, 16'h0,    32'h100, 1, 0, 32'h00, 0, 0, 2'd0, 1, 0, 0};
    vt[15] = '{0, 0, 0, 0, 2'b11, 16'h0,    32'h0,   1, 0, 32'h04, 1, 0, 2'd0, 0, 0, 0};

    rst = 1; stall = 0; BrPre = 0; redirect_valid = 0; PreWrong = 2'b10;
    instr_IF = 0; redirect_pc = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      rst = vt[i].rst; stall = vt[i].stall; BrPre = vt[i].brpre;
      redirect_valid = vt[i].rv; PreWrong = vt[i].pw; redirect_pc = vt[i].rpc;
      instr_IF = {16'h1000, vt[i].imm};
      #3;
      if (vt[i].chk_flush) check($sformatf("vec%0d flush_IF", i), 32'(flush_IF), 32'(vt[i].exp_flush));
      @(posedge clk); #1;
      check($sformatf("vec%0d PC", i), PC, vt[i].exp_pc);
      check($sformatf("vec%0d BranchPC_IF", i), 32'(BranchPC_IF), 32'(vt[i].exp_pc[3:2]));
      check($sformatf("vec%0d valid_ID", i), 32'(valid_ID), 32'(vt[i].exp_valid));
      check($sformatf("vec%0d BrPre_ID", i), 32'(BrPre_ID), 32'(vt[i].exp_brpre_id));
      check($sformatf("vec%0d BranchPC_ID", i), 32'(BranchPC_ID), 32'(vt[i].exp_bpc_id));
`ifdef BRPRED_STATS_EN
      if (vt[i].chk_cnt) begin
        check($sformatf("vec%0d branch_cnt", i), branch_cnt, vt[i].exp_bc);
        check($sformatf("vec%0d mispred_cnt", i), mispred_cnt, vt[i].exp_mc);
      end
`endif
    end

    // randomized run: start from a known reset so the model state is defined
    rst = 1; stall = 0; redirect_valid = 0; BrPre = 0;
    @(posedge clk); #1;
    m_pc = 0; m_pc4 = 0; m_tgt = 0; m_valid = 0; m_brpre = 0; m_bpc = 0; m_bc = 0; m_mc = 0;

    for (int c = 0; c < 2000; c++) begin
      logic        exp_flush, mis_nt, mis_t, bubble;
      logic [31:0] seq, tgt, nxt;
      rst            = ($urandom_range(0, 40) == 0);
      stall          = ($urandom_range(0, 4) == 0);
      BrPre          = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      PreWrong       = 2'($urandom_range(0, 3));
      redirect_pc    = {$urandom} & 32'hFFFF_FFFC;
      instr_IF       = $urandom;

      mis_nt = m_valid && (PreWrong == 2'b01);
      mis_t  = m_valid && (PreWrong == 2'b11);
      bubble = mis_nt || mis_t || redirect_valid;
      exp_flush = !stall && bubble;
      #3;
      check("rand flush_IF", 32'(flush_IF), 32'(exp_flush));

      seq = m_pc + 4;
      tgt = seq + 32'($signed(instr_IF[15:0])) * 4;
      if (rst) begin
        m_pc = 0; m_valid = 0; m_brpre = 0; m_bpc = 0; m_pc4 = 0; m_tgt = 0; m_bc = 0; m_mc = 0;
      end else if (!stall) begin
        if (m_valid && PreWrong != 2'b10 && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
        if ((mis_nt || mis_t) && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
        if (mis_nt)              nxt = m_pc4;
        else if (mis_t)          nxt = m_tgt;
        else if (redirect_valid) nxt = redirect_pc;
        else if (BrPre)          nxt = tgt;
        else                     nxt = seq;
        if (bubble) begin
          m_valid = 0; m_brpre = 0; m_bpc = 0;
        end else begin
          m_valid = 1; m_brpre = BrPre; m_bpc = m_pc[3:2]; m_pc4 = seq; m_tgt = tgt;
        end
        m_pc = nxt;
      end

      @(posedge clk); #1;
      check("rand PC", PC, m_pc);
      check("rand BranchPC_IF", 32'(BranchPC_IF), 32'(m_pc[3:2]));
      check("rand valid_ID", 32'(valid_ID), 32'(m_valid));
      check("rand BrPre_ID", 32'(BrPre_ID), 32'(m_brpre));
      check("rand BranchPC_ID", 32'(BranchPC_ID), 32'(m_bpc));
`ifdef BRPRED_STATS_EN
      check("rand branch_cnt", branch_cnt, m_bc);
      check("rand mispred_cnt", mispred_cnt, m_mc);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

IF-stage program-counter controller that sits directly upstream of the branch predictor and comparator. Each cycle it provides the fetch PC and the predictor index `BranchPC_IF`, and takes the predictor's `BrPre` to steer the fetch down the predicted path. It also carries the branch's fall-through and target addresses into ID. When the comparator reports `PreWrong`, it redirects fetch to the correct path and flushes the wrong-path instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  pipeline hold; PC and ID-stage registers keep their values.
- `instr_IF`  in  32  instruction word fetched at `PC`.
- `BrPre`  in  1  predictor output for `instr_IF`; already gated to beq/bne by the predictor.
- `PreWrong`  in  2  comparator result for the instruction in ID:
  - 00 = predicted right
  - 01 = predicted taken, actually not taken
  - 10 = not a branch
  - 11 = predicted not taken, actually taken
- `redirect_valid`  in  1  ID-stage jump (j/jal/jr) resolved this cycle.
- `redirect_pc`  in  32  jump destination.
- `PC`  out  32  fetch address; reset `RESET_PC`.
- `BranchPC_IF`  out  2  equals `PC[3:2]`; reset 0.
- `BranchPC_ID`  out  2  registered `BranchPC_IF` of the instruction now in ID; reset 0.
- `BrPre_ID`  out  1  registered prediction of the instruction in ID; reset 0.
- `valid_ID`  out  1  ID slot holds a real instruction; reset 0.
- `flush_IF`  out  1  kill the instruction currently in IF (combinational).

## Operation
- Definitions:
  - `pc4_IF = PC + 4`
  - `tgt_IF = pc4_IF + {{14{instr_IF[15]}}, instr_IF[15:0], 2'b00}`
  - All arithmetic is 32-bit modulo; wrap-around is silent.
- ID registers: `pc4_ID`, `tgt_ID`, `BrPre_ID`, `BranchPC_ID`, `valid_ID`.
- `mispredict = valid_ID & (PreWrong == 2'b01 | PreWrong == 2'b11)`.
- Next-PC priority, evaluated when `stall` = 0 (highest first):
  1. `rst`: PC ← `RESET_PC`; all ID registers ← 0.
  2. `mispredict` with `PreWrong` = 01: PC ← `pc4_ID`.
  3. `mispredict` with `PreWrong` = 11: PC ← `tgt_ID`.
  4. `redirect_valid`: PC ← `redirect_pc`.
  5. `BrPre`: PC ← `tgt_IF`.
  6. Otherwise: PC ← `pc4_IF`.
- ID-register load when `stall` = 0:
  - On cases 2–4, load a bubble: `valid_ID` = 0, `BrPre_ID` = 0, `BranchPC_ID` = 0.
  - Otherwise capture `pc4_IF`, `tgt_IF`, `BrPre`, `PC[3:2]`, and set `valid_ID` = 1.
- `flush_IF = ~stall & (mispredict | redirect_valid)`.
- Stall handling:
  - `stall` = 1 holds every register unchanged and forces `flush_IF` = 0.
  - A `PreWrong` or `redirect_valid` presented during a stall is ignored; ID re-presents it once the stall drops.
- `rst` overrides `stall`.
- `PreWrong` is ignored whenever `valid_ID` = 0, including the cycle after reset and the cycle after a flush.

## Timing
- The PC register has 1-cycle latency: the decision in cycle N is visible on `PC` in cycle N+1.
- Correct predictions cost 0 bubbles, including predicted-taken branches (target is computed in IF).
- A mispredict or jump costs exactly 1 bubble: the flushed IF slot enters ID as `valid_ID` = 0.
- Back-to-back branches: when the branch in ID mispredicts, the branch in IF is flushed and its `BrPre` is discarded.
- Reset mid-operation: the cycle after `rst`, `PC` = `RESET_PC`, `valid_ID` = 0, and `flush_IF` = 0.

## Configuration
- `BRPRED_STATS_EN` defined:
  - Adds output ports `branch_cnt` (32) and `mispred_cnt` (32), both reset to 0.
  - `branch_cnt` increments on each non-stalled cycle with `valid_ID` and `PreWrong` ≠ 10.
  - `mispred_cnt` increments on each non-stalled cycle with `mispredict`.
  - Both counters saturate at 32'hFFFF_FFFF.
- `BRPRED_STATS_EN` undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then 3 cycles with `BrPre` = 0 and `PreWrong` = 10 → `PC` = 0, 4, 8, 12; `BranchPC_IF` = 0, 1, 2, 3; `valid_ID` = 1 from cycle 2.
- `PC` = 0x40, `instr_IF` imm = 0x0003, `BrPre` = 1 → next `PC` = 0x50; `BrPre_ID` = 1; `BranchPC_ID` = 0.
- That branch in ID with `PreWrong` = 01 → `flush_IF` = 1; next `PC` = 0x44; next `valid_ID` = 0; `mispred_cnt` +1.
- Branch at 0x80, imm = 0xFFFF, predicted not taken, then `PreWrong` = 11 in ID → next `PC` = 0x80; bubble inserted in ID.
- `stall` = 1 for 2 cycles while `PreWrong` = 11 → `PC` and ID registers frozen, `flush_IF` = 0; redirect happens on the first unstalled cycle.
- `rst` asserted together with `stall` and `redirect_valid` (`redirect_pc` = 0x100) → next `PC` = `RESET_PC`; `valid_ID` = 0; counters = 0.
